// File: rtl/hs32_mem_pkg.sv
// Shared hs32 memory bus definitions.
// Used by the SRAM responder, the arbiter and the requesters.
package hs32_mem_pkg;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // done is a single-cycle pulse, one per accepted request
  localparam int DONE_PULSE_CYCLES = 1;

endpackage

// File: rtl/hs32_sram16.sv
// hs32 memory bus responder for a 16-bit asynchronous SRAM.
// Each 32-bit request is served as a LO then a HI halfword access.
module hs32_sram16
  import hs32_mem_pkg::*;
#(
  parameter int AW      = 17,
  parameter int WAIT_RD = 2,
  parameter int WAIT_WR = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [31:0]   addr,
  input  logic          rw,
  input  logic [31:0]   dout,
  input  logic          valid,
  output logic [31:0]   din,
  output logic          done,
  output logic [AW-1:0] sram_a,
  output logic [15:0]   sram_dq_o,
  input  logic [15:0]   sram_dq_i,
  output logic          sram_dq_oe,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n
);

  localparam int WMAX =
    (WAIT_RD > WAIT_WR) ? WAIT_RD : WAIT_WR;
  localparam int CW = $clog2(WMAX + 1);

  localparam logic [CW-1:0] NRD = CW'(WAIT_RD);
  localparam logic [CW-1:0] NWR = CW'(WAIT_WR);
  localparam logic [CW-1:0] ONE = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rw_q, rw_n;
  logic [AW-2:0] wa_q, wa_n;
  logic [31:0]   wd_q, wd_n;
  logic [CW-1:0] lim, lim_n, last;
  logic          take;

  logic          done_d;
  logic [AW-1:0] a_d;
  logic [15:0]   dq_d;
  logic          oen_d;
  logic          ce_d;
  logic          oe_d;
  logic          we_d;

  logic unused_addr;
  assign unused_addr = ^{addr[31:AW+1], addr[1:0]};

  // request fields are frozen from the accepting edge to the next IDLE
  assign take  = (st == S_IDLE) && valid;
  assign rw_n  = take ? rw : rw_q;
  assign wa_n  = take ? addr[AW:2] : wa_q;
  assign wd_n  = take ? dout : wd_q;
  assign lim   = (rw_q == RW_WRITE) ? NWR : NRD;
  assign lim_n = (rw_n == RW_WRITE) ? NWR : NRD;
  assign last  = lim - ONE;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st   <= S_IDLE;
      cnt  <= '0;
      rw_q <= RW_READ;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      rw_q <= rw_n;
      wa_q <= wa_n;
      wd_q <= wd_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    unique case (st)
      S_IDLE: begin
        if (valid) begin
          st_n  = S_LO;
          cnt_n = '0;
        end
      end
      S_LO: begin
        if (cnt == lim) begin
          st_n  = S_HI;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_HI: begin
        if (cnt == lim) begin
          st_n  = S_DONE;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_DONE:  st_n = S_IDLE;
      default: st_n = S_IDLE;
    endcase
  end

  // pins are registered from the upcoming state so strobes never glitch
  always_comb begin
    done_d = 1'b0;
    a_d    = sram_a;
    dq_d   = sram_dq_o;
    oen_d  = 1'b0;
    ce_d   = 1'b1;
    oe_d   = 1'b1;
    we_d   = 1'b1;
    unique case (st_n)
      S_LO, S_HI: begin
        ce_d = 1'b0;
        a_d  = {wa_n, st_n == S_HI};
        if (cnt_n < lim_n) begin
          if (rw_n == RW_WRITE) we_d = 1'b0;
          else                  oe_d = 1'b0;
        end
        if (rw_n == RW_WRITE) begin
          oen_d = 1'b1;
          dq_d  = (st_n == S_HI) ? wd_n[31:16]
                                 : wd_n[15:0];
        end
      end
      S_DONE:  done_d = 1'b1;
      default: done_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      din        <= '0;
      done       <= 1'b0;
      sram_a     <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      done       <= done_d;
      sram_a     <= a_d;
      sram_dq_o  <= dq_d;
      sram_dq_oe <= oen_d;
      sram_ce_n  <= ce_d;
      sram_oe_n  <= oe_d;
      sram_we_n  <= we_d;
      // sample on the last strobe edge, before oe_n rises
      if (rw_q == RW_READ && cnt == last) begin
        if (st == S_LO) din[15:0]  <= sram_dq_i;
        if (st == S_HI) din[31:16] <= sram_dq_i;
      end
    end
  end

endmodule

// File: tb/tb_hs32_sram16.sv
// Bench for hs32_sram16: transaction model, SRAM model,
// per-cycle compare plus directed literal checks.
module tb_hs32_sram16;
  import hs32_mem_pkg::*;

  localparam int AW = 17;
  localparam int RD = 2;
  localparam int WR = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic [31:0]   addr, dout;
  logic          rw, valid, valid1;
  logic [31:0]   din, din1;
  logic          done, done1;
  logic [AW-1:0] sram_a, sram_a1;
  logic [15:0]   dq_o, dq_o1, dq_i, dq_i1;
  logic          dq_oe, dq_oe1;
  logic          ce_n, oe_n, we_n;
  logic          ce_n1, oe_n1, we_n1;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem     [0:(1<<AW)-1];
  logic [15:0] ref_mem [0:(1<<AW)-1];
  logic [AW-1:0] sa[$];
  logic [15:0]   sd[$];

  always #5 clk = ~clk;

  hs32_sram16 #(.AW(AW), .WAIT_RD(RD), .WAIT_WR(WR)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .rw(rw),
    .dout(dout), .valid(valid), .din(din), .done(done),
    .sram_a(sram_a), .sram_dq_o(dq_o), .sram_dq_i(dq_i),
    .sram_dq_oe(dq_oe), .sram_ce_n(ce_n),
    .sram_oe_n(oe_n), .sram_we_n(we_n)
  );

  hs32_sram16 #(.AW(AW), .WAIT_RD(1), .WAIT_WR(WR)) dut1 (
    .clk(clk), .rstn(rstn), .addr(addr), .rw(rw),
    .dout(dout), .valid(valid1), .din(din1), .done(done1),
    .sram_a(sram_a1), .sram_dq_o(dq_o1), .sram_dq_i(dq_i1),
    .sram_dq_oe(dq_oe1), .sram_ce_n(ce_n1),
    .sram_oe_n(oe_n1), .sram_we_n(we_n1)
  );

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      mem[i]     = 16'(i) ^ 16'h1234;
      ref_mem[i] = 16'(i) ^ 16'h1234;
    end
  end

  // board SRAM: drives junk when not output-enabled
  assign dq_i  = (!ce_n && !oe_n) ? mem[sram_a] : 16'hA5A5;
  assign dq_i1 = (!ce_n1 && !oe_n1) ? mem[sram_a1] : 16'hA5A5;
  always @(posedge clk)
    if (!ce_n && !we_n && dq_oe) mem[sram_a] <= dq_o;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // transaction model: k = cycle index since the accepting edge
  int k = 0;
  int nm = RD;
  int mh, mc;
  logic          m_rw = RW_READ;
  logic [AW-2:0] m_wa = '0;
  logic [31:0]   m_wd = '0;
  logic [31:0]   din_exp = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k = 0;
      din_exp = '0;
    end else begin
      if (k >= 1 && k <= 2*nm+2) begin
        mh = (k-1) / (nm+1);
        mc = (k-1) % (nm+1);
        if (m_rw == RW_WRITE) begin
          if (mc < nm)
            ref_mem[{m_wa, mh[0]}] = mh[0] ? m_wd[31:16] : m_wd[15:0];
        end else if (mc == nm-1) begin
          if (mh == 0) din_exp[15:0]  = ref_mem[{m_wa, 1'b0}];
          else         din_exp[31:16] = ref_mem[{m_wa, 1'b1}];
        end
      end
      if (k == 2*nm+3) k = 0;
      else if (k > 0) k++;
      else if (valid) begin
        k = 1;
        m_rw = rw;
        m_wa = addr[AW:2];
        m_wd = dout;
        nm = (rw == RW_WRITE) ? WR : RD;
      end
    end
  end

  int ch, cc;
  logic ph, e_done, e_ce, e_oe, e_we, e_oen;

  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_ctl", {done, ce_n, oe_n, we_n, dq_oe}, 5'b01110);
      chk("rst_din", din, 32'h0);
      chk("rst_a_dq", {sram_a, dq_o}, '0);
    end else begin
      ph = (k >= 1 && k <= 2*nm+2);
      ch = ph ? (k-1) / (nm+1) : 0;
      cc = ph ? (k-1) % (nm+1) : 0;
      e_done = (k == 2*nm+3);
      e_ce   = !ph;
      e_we   = !(ph && m_rw == RW_WRITE && cc < nm);
      e_oe   = !(ph && m_rw == RW_READ && cc < nm);
      e_oen  = ph && m_rw == RW_WRITE;
      chk("ctl", {done, ce_n, oe_n, we_n, dq_oe},
          {e_done, e_ce, e_oe, e_we, e_oen});
      chk("din", din, din_exp);
      if (ph) chk("sram_a", sram_a, {m_wa, ch[0]});
      if (ph && m_rw == RW_WRITE)
        chk("dq_o", dq_o, ch[0] ? m_wd[31:16] : m_wd[15:0]);
    end
  end

  task automatic wait_done(output int lat, output int ns);
    lat = 0;
    ns = 0;
    sa.delete();
    sd.delete();
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (!oe_n || !we_n) begin
        ns++;
        sa.push_back(sram_a);
        sd.push_back(dq_o);
      end
      if (done) break;
    end
    chk("done_seen", done, 1'b1);
    valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] a, input logic w,
                        input logic [31:0] d,
                        output int lat, output int ns);
    addr = a;
    rw = w;
    dout = d;
    valid = 1'b1;
    @(posedge clk);
    #1;
    wait_done(lat, ns);
  endtask

  initial begin
    int lat, ns, d1, d2, np;
    logic [AW-1:0] ea [4];
    ea = '{17'd8, 17'd8, 17'd9, 17'd9};

    // 1: reset held with valid high, then start on first edge
    rstn = 1'b0; valid = 1'b1; valid1 = 1'b0;
    addr = 32'h0; rw = RW_READ; dout = 32'h0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("start_first_edge", {ce_n, oe_n}, 2'b00);
    wait_done(lat, ns);
    chk("t1_lat", lat, 7);
    chk("t1_din", din, 32'h12351234);

    // 2: write
    do_req(32'h10, RW_WRITE, 32'hDEADBEEF, lat, ns);
    chk("t2_lat", lat, 7);
    chk("t2_we_cycles", ns, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_sa", sa[i], ea[i]);
      chk("t2_sd", sd[i], (i < 2) ? 16'hBEEF : 16'hDEAD);
    end
    chk("t2_din_kept", din, 32'h12351234);

    // 3: read back
    do_req(32'h10, RW_READ, 32'h0, lat, ns);
    chk("t3_lat", lat, 7);
    chk("t3_oe_cycles", ns, 4);
    chk("t3_din", din, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) chk("t3_sa", sa[i], ea[i]);

    // 4: back-to-back with valid held across done
    addr = 32'h80; rw = RW_WRITE; dout = 32'h11112222;
    valid = 1'b1;
    d1 = -1; d2 = -1; np = 0;
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        np++;
        if (d1 < 0) begin
          d1 = i;
          addr = 32'h10;
          rw = RW_READ;
        end else begin
          d2 = i;
          valid = 1'b0;
          chk("t4_din", din, 32'hDEADBEEF);
        end
      end
    end
    chk("t4_pulses", np, 2);
    chk("t4_first", d1, 7);
    chk("t4_spacing", d2 - d1, 8);
    @(posedge clk);
    #1;

    // 5: reset during HI of a write
    addr = 32'h40; rw = RW_WRITE; dout = 32'h12345678;
    valid = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;
    valid = 1'b0;
    #1 chk("t5_strobes", {ce_n, we_n, oe_n, dq_oe}, 4'b1110);
    np = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) np++;
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done) np++;
    end
    chk("t5_no_done", np, 0);
    @(posedge clk);
    #1;
    do_req(32'h40, RW_READ, 32'h0, lat, ns);
    chk("t5_din", din, 32'h12155678);

    // 6: alias and WAIT_RD=1 latency
    do_req(32'h0004_0010, RW_READ, 32'h0, lat, ns);
    chk("t6_alias_lo", sa[0], 17'd8);
    chk("t6_alias_hi", sa[2], 17'd9);
    chk("t6_alias_din", din, 32'hDEADBEEF);
    addr = 32'h0004_0010; rw = RW_READ;
    valid1 = 1'b1;
    @(posedge clk);
    #1;
    lat = 0; ns = 0;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (!oe_n1) ns++;
      if (done1) break;
    end
    valid1 = 1'b0;
    chk("t6_done1", done1, 1'b1);
    chk("t6_lat", lat, 5);
    chk("t6_oe_cycles", ns, 2);
    chk("t6_din1", din1, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
